// File: rtl/wb_mux_pkg.sv
// Shared writeback-select constants and the default beat layout.
package wb_mux_pkg;

    localparam int WB_SEL_ALU = 0;
    localparam int WB_SEL_MEM = 1;
    localparam int WB_SEL_PC4 = 2;
    localparam int WB_SEL_IMM = 3;

    localparam int WB_W     = 32;
    localparam int WB_SEL_W = 2;

    typedef struct packed {
        logic [WB_W-1:0]     data;
        logic [WB_SEL_W-1:0] sel;
        logic                err;
    } wb_beat_t;

endpackage

// File: rtl/wb_mux_n.sv
// Combinational NUM_IN:1 writeback selector with out-of-range flag.
module wb_mux_n
    import wb_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                data = in_data[k*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_mux_stage.sv
// Registered N-way writeback select stage with valid/ready handshake.
// WB_MUX_SKID_EN adds a skid register so in_ready is fully registered.
module wb_mux_stage
    import wb_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } beat_t;

    logic [WIDTH-1:0] mux_data;
    logic             mux_err;
    beat_t            new_beat;
    beat_t            main_q;
    logic             main_v;
    logic             in_fire;

    wb_mux_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .in_data (in_data),
        .sel     (in_sel),
        .data    (mux_data),
        .err     (mux_err)
    );

    assign new_beat = '{data: mux_data, sel: in_sel, err: mux_err};
    assign in_fire  = in_valid && in_ready;

`ifdef WB_MUX_SKID_EN
    beat_t skid_q;
    logic  skid_v;
    logic  rdy_q;

    // rdy_q mirrors "skid empty"; gated by rst so it reads 0 during reset
    assign in_ready = rdy_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            main_v <= 1'b0;
            skid_q <= '0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
        end else if (!main_v || out_ready) begin
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
                rdy_q  <= 1'b1;
            end else begin
                main_v <= in_fire;
                if (in_fire) begin
                    main_q <= new_beat;
                end
            end
        end else if (in_fire) begin
            skid_q <= new_beat;
            skid_v <= 1'b1;
            rdy_q  <= 1'b0;
        end
    end
`else
    assign in_ready = !rst && (!main_v || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            main_v <= 1'b0;
        end else if (!main_v || out_ready) begin
            main_v <= in_fire;
            if (in_fire) begin
                main_q <= new_beat;
            end
        end
    end
`endif

    assign out_data  = main_q.data;
    assign out_sel   = main_q.sel;
    assign out_err   = main_q.err;
    assign out_valid = main_v;

endmodule

// File: tb/tb_wb_mux_stage.sv
// Directed and random checks for wb_mux_stage in three configurations.
module tb_wb_mux_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] d4 = '0;
    logic [1:0]   s4 = '0;
    logic         v4 = 1'b0;
    logic         r4 = 1'b0;
    logic         ir4;
    logic [31:0]  od4;
    logic [1:0]   os4;
    logic         oe4;
    logic         ov4;

    logic [95:0]  d3 = '0;
    logic [1:0]   s3 = '0;
    logic         v3 = 1'b0;
    logic         r3 = 1'b0;
    logic         ir3;
    logic [31:0]  od3;
    logic [1:0]   os3;
    logic         oe3;
    logic         ov3;

    logic [511:0] d8 = '0;
    logic [2:0]   s8 = '0;
    logic         v8 = 1'b0;
    logic         r8 = 1'b0;
    logic         ir8;
    logic [63:0]  od8;
    logic [2:0]   os8;
    logic         oe8;
    logic         ov8;

    wb_mux_stage #(.WIDTH(32), .NUM_IN(4)) u4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_sel(s4),
        .in_valid(v4), .in_ready(ir4), .out_data(od4), .out_sel(os4),
        .out_err(oe4), .out_valid(ov4), .out_ready(r4)
    );

    wb_mux_stage #(.WIDTH(32), .NUM_IN(3)) u3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_sel(s3),
        .in_valid(v3), .in_ready(ir3), .out_data(od3), .out_sel(os3),
        .out_err(oe3), .out_valid(ov3), .out_ready(r3)
    );

    wb_mux_stage #(.WIDTH(64), .NUM_IN(8)) u8 (
        .clk(clk), .rst(rst), .in_data(d8), .in_sel(s8),
        .in_valid(v8), .in_ready(ir8), .out_data(od8), .out_sel(os8),
        .out_err(oe8), .out_valid(ov8), .out_ready(r8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (ov4 !== 1'b0 || od4 !== 32'h0 || os4 !== 2'd0 || oe4 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out got v=%b d=%h s=%0d e=%b want 0/0/0/0",
                     ov4, od4, os4, oe4);
        end
        n_cmp++;
        if (ir4 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready got %b want 0", ir4);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ir4 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready got %b want 1", ir4);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        d4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        r4 = 1'b1;
        v4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s4 = 2'(k);
            tick();
            e = 32'h11111111 * (k + 1);
            n_cmp++;
            if (od4 !== e || ov4 !== 1'b1 || oe4 !== 1'b0 || os4 !== 2'(k)) begin
                n_bad++;
                $display("FAIL stream%0d got d=%h v=%b e=%b s=%0d want %h/1/0/%0d",
                         k, od4, ov4, oe4, os4, e, k);
            end
        end
        v4 = 1'b0;
        tick();
        n_cmp++;
        if (ov4 !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_drain got v=%b want 0", ov4);
        end
    endtask

    task automatic test_backpressure();
        r4 = 1'b0;
        v4 = 1'b1;
        s4 = 2'd3;
        tick();
        s4 = 2'd2;
        #1;
`ifdef WB_MUX_SKID_EN
        n_cmp++;
        if (ir4 !== 1'b1) begin
            n_bad++;
            $display("FAIL skid_ready1 got %b want 1", ir4);
        end
        tick();
        n_cmp++;
        if (ir4 !== 1'b0 || od4 !== 32'h44444444) begin
            n_bad++;
            $display("FAIL skid_full got r=%b d=%h want 0/44444444", ir4, od4);
        end
        s4 = 2'd1;
        tick();
        n_cmp++;
        if (ir4 !== 1'b0 || od4 !== 32'h44444444 || ov4 !== 1'b1) begin
            n_bad++;
            $display("FAIL skid_hold got r=%b d=%h v=%b want 0/44444444/1",
                     ir4, od4, ov4);
        end
        r4 = 1'b1;
        tick();
        n_cmp++;
        if (od4 !== 32'h33333333 || ir4 !== 1'b1) begin
            n_bad++;
            $display("FAIL skid_move got d=%h r=%b want 33333333/1", od4, ir4);
        end
        tick();
        n_cmp++;
        if (od4 !== 32'h22222222 || ov4 !== 1'b1) begin
            n_bad++;
            $display("FAIL skid_third got d=%h v=%b want 22222222/1", od4, ov4);
        end
`else
        n_cmp++;
        if (ir4 !== 1'b0 || od4 !== 32'h44444444 || ov4 !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_stall got r=%b d=%h v=%b want 0/44444444/1",
                     ir4, od4, ov4);
        end
        tick();
        n_cmp++;
        if (od4 !== 32'h44444444 || ov4 !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold got d=%h v=%b want 44444444/1", od4, ov4);
        end
        r4 = 1'b1;
        #1;
        n_cmp++;
        if (ir4 !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release_ready got %b want 1", ir4);
        end
        tick();
        n_cmp++;
        if (od4 !== 32'h33333333 || ov4 !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_new got d=%h v=%b want 33333333/1", od4, ov4);
        end
`endif
        v4 = 1'b0;
        tick();
        n_cmp++;
        if (ov4 !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain got v=%b want 0", ov4);
        end
    endtask

    task automatic test_out_of_range();
        d3 = {32'h33333333, 32'h22222222, 32'h11111111};
        r3 = 1'b1;
        v3 = 1'b1;
        s3 = 2'd3;
        tick();
        n_cmp++;
        if (od3 !== 32'h0 || oe3 !== 1'b1 || os3 !== 2'd3 || ov3 !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_bad got d=%h e=%b s=%0d v=%b want 0/1/3/1",
                     od3, oe3, os3, ov3);
        end
        s3 = 2'd1;
        tick();
        n_cmp++;
        if (od3 !== 32'h22222222 || oe3 !== 1'b0 || os3 !== 2'd1) begin
            n_bad++;
            $display("FAIL oor_good got d=%h e=%b s=%0d want 22222222/0/1",
                     od3, oe3, os3);
        end
        v3 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        r4 = 1'b0;
        v4 = 1'b1;
        s4 = 2'd0;
        tick();
        s4 = 2'd1;
        tick();
        v4 = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ir4 !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_ready got %b want 0", ir4);
        end
        tick();
        n_cmp++;
        if (ov4 !== 1'b0 || od4 !== 32'h0) begin
            n_bad++;
            $display("FAIL rmid_out got v=%b d=%h want 0/0", ov4, od4);
        end
        rst = 1'b0;
        r4 = 1'b1;
        #1;
        n_cmp++;
        if (ir4 !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_release got %b want 1", ir4);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (ov4 !== 1'b0) begin
                n_bad++;
                $display("FAIL rmid_stale%0d got v=%b want 0", k, ov4);
            end
        end
    endtask

    task automatic test_sweep();
        logic [63:0] src [8];
        logic [66:0] q [$];
        logic [66:0] exp_b;
        logic        stalled;
        logic [63:0] held;
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < 8; k++) begin
                src[k] = {$urandom, $urandom};
                d8[k*64 +: 64] = src[k];
            end
            v8 = 1'($urandom % 2);
            s8 = 3'($urandom % 8);
            r8 = ($urandom % 4) != 0;
            #1;
            if (stalled) begin
                n_cmp++;
                if (od8 !== held || ov8 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sweep_stable c=%0d got d=%h v=%b want %h/1",
                             c, od8, ov8, held);
                end
            end
            if (ov8 && r8) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sweep_extra c=%0d got d=%h want none", c, od8);
                end else begin
                    exp_b = q.pop_front();
                    if ({od8, os8} !== exp_b || oe8 !== 1'b0) begin
                        n_bad++;
                        $display("FAIL sweep_beat c=%0d got %h/%0d want %h/%0d",
                                 c, od8, os8, exp_b[66:3], exp_b[2:0]);
                    end
                end
            end
            if (v8 && ir8) begin
                q.push_back({src[s8], s8});
            end
            stalled = ov8 && !r8;
            held = od8;
            tick();
        end
        v8 = 1'b0;
        r8 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ov8) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sweep_drain_extra got d=%h want none", od8);
                end else begin
                    exp_b = q.pop_front();
                    if ({od8, os8} !== exp_b) begin
                        n_bad++;
                        $display("FAIL sweep_drain got %h want %h",
                                 od8, exp_b[66:3]);
                    end
                end
            end
            tick();
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL sweep_lost got %0d left want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
